fp_operand_stage: RTL and testbench

FP_OPERAND_STAGE -- requirements
Module: fp_operand_stage

---
 rtl/fp_operand_stage.sv | 176 +++++++++++++++++
 tb/tb_fp_operand_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_stage.sv
// ---------------------------------------------------------------------------
// fp_operand_stage
//   Operand-preparation stage in front of a single-precision FP adder.
//   Operand sets {op, a, b} are buffered in a DEPTH-entry FIFO. When the
//   output register is free (or being drained), the FIFO head is
//   preprocessed and loaded into it:
//     - the effective sign of b is b[31] ^ op, so a subtract becomes an add
//       with b negated
//     - the operands are ordered by magnitude (larger one on out_big);
//       equal magnitudes keep a on out_big
//     - the exponent difference and the effective-subtraction flag are
//       precomputed for the adder's alignment shifter
//
//   Optional feature: define FP_SPECIAL_DETECT_EN to build zero/inf/NaN
//   detection. Without it, out_zero/out_inf/out_nan are tied to 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake for {op, a, b}
//   op, a, b            0 = a + b, 1 = a - b; IEEE-754 single operands
//   flush               synchronous discard of FIFO and output register
//   out_valid/out_ready downstream handshake for the preprocessed set
//   out_big, out_small  larger/smaller-magnitude operand, effective signs
//   out_exp_diff        out_big exponent minus out_small exponent
//   out_eff_sub         effective mantissa subtraction
//   out_swapped         b was placed on out_big
//   out_zero/inf/nan    special-operand flags
//   occupancy           FIFO entry count (output register not included)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready. A producer holding valid keeps its data stable until the
// transfer; ready never depends combinationally on valid.
// ---------------------------------------------------------------------------
module fp_operand_stage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op,
    input  logic [31:0]              a,
    input  logic [31:0]              b,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_big,
    output logic [31:0]              out_small,
    output logic [7:0]               out_exp_diff,
    output logic                     out_eff_sub,
    output logic                     out_swapped,
    output logic                     out_zero,
    output logic                     out_inf,
    output logic                     out_nan,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // in_ready comes from registered count only.
    assign in_ready  = (count != FULL_CNT);
    assign occupancy = count;
    assign push      = in_valid && in_ready;
    // The output register takes the head whenever it is empty or draining.
    assign pop       = (count != '0) && (!out_valid || out_ready);

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {op, a, b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Preprocessing of the FIFO head.
    logic        h_op;
    logic [31:0] h_a;
    logic [31:0] h_b;
    logic        b_sign_eff;
    logic [31:0] b_eff;
    logic        swap;
    logic [31:0] n_big;
    logic [31:0] n_small;

    always_comb begin
        {h_op, h_a, h_b} = mem[rptr];
        b_sign_eff       = h_b[31] ^ h_op;
        b_eff            = {b_sign_eff, h_b[30:0]};
        swap             = (h_a[30:0] < h_b[30:0]);
        n_big            = swap ? b_eff : h_a;
        n_small          = swap ? h_a   : b_eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_big      <= '0;
            out_small    <= '0;
            out_exp_diff <= '0;
            out_eff_sub  <= 1'b0;
            out_swapped  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid    <= 1'b1;
            out_big      <= n_big;
            out_small    <= n_small;
            // Ordering by magnitude makes this subtraction non-negative.
            out_exp_diff <= n_big[30:23] - n_small[30:23];
            out_eff_sub  <= h_a[31] ^ b_sign_eff;
            out_swapped  <= swap;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FP_SPECIAL_DETECT_EN
    logic a_exp_max, b_exp_max, a_frac_nz, b_frac_nz;
    logic det_nan, det_inf, det_zero;

    always_comb begin
        a_exp_max = &h_a[30:23];
        b_exp_max = &h_b[30:23];
        a_frac_nz = |h_a[22:0];
        b_frac_nz = |h_b[22:0];
        det_nan   = (a_exp_max && a_frac_nz) || (b_exp_max && b_frac_nz);
        det_inf   = ((a_exp_max && !a_frac_nz) || (b_exp_max && !b_frac_nz))
                    && !det_nan;
        det_zero  = (h_a[30:0] == '0) && (h_b[30:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
            out_inf  <= 1'b0;
            out_nan  <= 1'b0;
        end else if (!flush && pop) begin
            out_zero <= det_zero;
            out_inf  <= det_inf;
            out_nan  <= det_nan;
        end
    end
`else
    assign out_zero = 1'b0;
    assign out_inf  = 1'b0;
    assign out_nan  = 1'b0;
`endif

endmodule

// File: tb/tb_fp_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_fp_operand_stage
//   Directed bench for fp_operand_stage (DEPTH = 4). Inputs are driven and
//   outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_fp_operand_stage;

    localparam int DEPTH = 4;
`ifdef FP_SPECIAL_DETECT_EN
    localparam logic SPEC = 1'b1;
`else
    localparam logic SPEC = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_big;
    logic [31:0] out_small;
    logic [7:0]  out_exp_diff;
    logic        out_eff_sub;
    logic        out_swapped;
    logic        out_zero;
    logic        out_inf;
    logic        out_nan;
    logic [$clog2(DEPTH):0] occupancy;

    int n_vec = 0;
    int n_err = 0;
    int accepted = 0;
    int exp_occ[6] = '{1, 1, 2, 3, 4, 4};

    fp_operand_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_big(out_big), .out_small(out_small),
        .out_exp_diff(out_exp_diff), .out_eff_sub(out_eff_sub),
        .out_swapped(out_swapped),
        .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan),
        .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push one set into an empty stage, check 2-edge latency, all outputs,
    // stability under back-pressure, then drain it.
    task automatic run_vec(input string tag, input logic o,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] e_big, input logic [31:0] e_small,
                           input logic [7:0] e_diff, input logic e_sub,
                           input logic e_swp, input logic e_z,
                           input logic e_i, input logic e_n);
        in_valid  = 1'b1;
        op        = o;
        a         = va;
        b         = vb;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk({tag, ".valid_n"}, out_valid, 32'd0);
        chk({tag, ".occ_n"}, occupancy, 32'd1);
        tick();
        chk({tag, ".valid_n1"}, out_valid, 32'd1);
        chk({tag, ".occ_n1"}, occupancy, 32'd0);
        chk({tag, ".big"}, out_big, e_big);
        chk({tag, ".small"}, out_small, e_small);
        chk({tag, ".diff"}, out_exp_diff, e_diff);
        chk({tag, ".eff_sub"}, out_eff_sub, e_sub);
        chk({tag, ".swapped"}, out_swapped, e_swp);
        chk({tag, ".zero"}, out_zero, e_z);
        chk({tag, ".inf"}, out_inf, e_i);
        chk({tag, ".nan"}, out_nan, e_n);
        tick();
        chk({tag, ".hold_valid"}, out_valid, 32'd1);
        chk({tag, ".hold_big"}, out_big, e_big);
        chk({tag, ".hold_small"}, out_small, e_small);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".drained"}, out_valid, 32'd0);
    endtask

    initial begin
        // reset state
        tick();
        chk("rst.occ", occupancy, 32'd0);
        chk("rst.valid", out_valid, 32'd0);
        chk("rst.in_ready", in_ready, 32'd1);
        chk("rst.big", out_big, 32'd0);
        chk("rst.small", out_small, 32'd0);
        tick();
        rst_n = 1'b1;

        // main function
        run_vec("v_add_swap", 1'b0, 32'h3F800000, 32'h40000000,
                32'h40000000, 32'h3F800000, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("v_sub", 1'b1, 32'h40400000, 32'h3F800000,
                32'h40400000, 32'hBF800000, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("v_equal", 1'b0, 32'h40000000, 32'hC0000000,
                32'h40000000, 32'hC0000000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("v_sub_swap", 1'b1, 32'h3F800000, 32'hC1200000,
                32'h41200000, 32'h3F800000, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("v_nan", 1'b0, 32'h7FC00000, 32'h3F800000,
                32'h7FC00000, 32'h3F800000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, SPEC);
        run_vec("v_inf", 1'b0, 32'h7F800000, 32'h3F800000,
                32'h7F800000, 32'h3F800000, 8'h80, 1'b0, 1'b0, 1'b0, SPEC, 1'b0);
        run_vec("v_zero", 1'b1, 32'h00000000, 32'h00000000,
                32'h00000000, 32'h80000000, 8'd0, 1'b1, 1'b0, SPEC, 1'b0, 1'b0);

        // fill with out_ready low: 6 offered, 5 accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 1'b0;
        b         = 32'h0;
        for (int i = 0; i < 6; i++) begin
            a = 32'h3F800000 | i;
            chk($sformatf("fill.in_ready%0d", i), in_ready, (i < 5) ? 32'd1 : 32'd0);
            if (in_ready) accepted++;
            tick();
            chk($sformatf("fill.occ%0d", i), occupancy, exp_occ[i]);
        end
        in_valid = 1'b0;
        chk("fill.accepted", accepted, 32'd5);
        chk("fill.head", out_big, 32'h3F800000);
        chk("fill.full_ready", in_ready, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pulse.in_ready", in_ready, 32'd1);
        chk("pulse.occ", occupancy, 32'd3);
        chk("pulse.valid", out_valid, 32'd1);
        chk("pulse.big", out_big, 32'h3F800001);

        // asynchronous reset mid-stream, no clock edge in between
        rst_n = 1'b0;
        #1;
        chk("arst.occ", occupancy, 32'd0);
        chk("arst.valid", out_valid, 32'd0);
        chk("arst.in_ready", in_ready, 32'd1);
        chk("arst.big", out_big, 32'd0);
        rst_n = 1'b1;
        #1;

        // first push after reset release, then flush with simultaneous push
        in_valid = 1'b1;
        a        = 32'h40000000;
        b        = 32'h3F800000;
        tick();
        chk("post_rst.occ", occupancy, 32'd1);
        tick();
        chk("pre_flush.occ", occupancy, 32'd1);
        chk("pre_flush.valid", out_valid, 32'd1);
        flush = 1'b1;
        chk("flush.in_ready", in_ready, 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.occ", occupancy, 32'd0);
        chk("flush.valid", out_valid, 32'd0);
        chk("flush.in_ready_after", in_ready, 32'd1);
        tick();
        chk("flush.still_empty", out_valid, 32'd0);
        chk("flush.occ_after", occupancy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
